// File: rtl/seg_scan_if.sv
// Host-side bus of the display scan controller: register writes and display controls in,
// multiplexed digit strobes and decoder drive out.
interface seg_scan_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] dig_mask;
  logic       lz_blank;
  logic [3:0] code;
  logic       code_en;
  logic [3:0] dig_sel;
  logic       frame;

  modport master (
    output wr_en, wr_addr, wr_data, dig_mask, lz_blank,
    input  code, code_en, dig_sel, frame
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, dig_mask, lz_blank,
    output code, code_en, dig_sel, frame
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller. Each digit slot lasts TICK_DIV cycles,
// the first of which drives guard (all-dark) outputs to avoid ghosting between digits.
module seg_scan_ctrl #(
  parameter int TICK_DIV = 4  // legal range 2..65535
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   bus
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {GUARD = 1'b0, SHOW = 1'b1} state_t;

  logic [3:0][3:0] regs;
  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic            tick;
  state_t          state, state_nxt;
  logic [3:0]      zero_up;
  logic            blank;

  logic [3:0] dig_sel_d, code_d;
  logic       code_en_d, frame_d;
  logic [3:0] dig_sel_q, code_q;
  logic       code_en_q, frame_q;

  // Digit register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          regs <= '0;
    else if (bus.wr_en)  regs[bus.wr_addr] <= bus.wr_data;
  end

  // Prescaler and digit index
  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= idx + 2'd1;
    end
  end

  // zero_up[i]: every register from digit i up to the top digit holds zero
  assign zero_up[3] = (regs[3] == 4'h0);
  for (genvar i = 0; i < 3; i++) begin : g_zero
    assign zero_up[i] = zero_up[i+1] & (regs[i] == 4'h0);
  end

  assign blank = bus.lz_blank & (idx != 2'd0) & zero_up[idx];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GUARD;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (tick)                state_nxt = GUARD;
    else if (state == GUARD) state_nxt = SHOW;
  end

  // FSM: output values to load at this edge, from pre-edge state
  always_comb begin
    dig_sel_d = '0;
    code_d    = '0;
    code_en_d = 1'b0;
    frame_d   = tick & (idx == 2'd3);
    if (state == SHOW) begin
      dig_sel_d = 4'b0001 << idx;
      code_d    = regs[idx];
      code_en_d = bus.dig_mask[idx] & ~blank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel_q <= '0;
      code_q    <= '0;
      code_en_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      dig_sel_q <= dig_sel_d;
      code_q    <= code_d;
      code_en_q <= code_en_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.dig_sel = dig_sel_q;
  assign bus.code    = code_q;
  assign bus.code_en = code_en_q;
  assign bus.frame   = frame_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (TICK_DIV=4): stimulus queues hand-computed outputs
// tagged with the edge count since reset release; a negedge monitor pops and compares.
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic [3:0] code;
    logic       en;
    logic       frame;
    string      name;
  } exp_t;

  exp_t sb[$];

  seg_scan_if bus();

  seg_scan_ctrl #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: expected at edge %0d, reached edge %0d unchecked", e.name, e.cyc, cyc);
      end else if (bus.dig_sel !== e.sel || bus.code !== e.code ||
                   bus.code_en !== e.en || bus.frame !== e.frame) begin
        bad++;
        $display("FAIL %s @%0d: got sel=%b code=%h en=%b frame=%b, want sel=%b code=%h en=%b frame=%b",
                 e.name, cyc, bus.dig_sel, bus.code, bus.code_en, bus.frame,
                 e.sel, e.code, e.en, e.frame);
      end
    end
  end

  task automatic expect_at(input int c, input logic [3:0] sel, input logic [3:0] code,
                           input logic en, input logic frame, input string name);
    exp_t e;
    e.cyc = c; e.sel = sel; e.code = code; e.en = en; e.frame = frame; e.name = name;
    sb.push_back(e);
  endtask

  task automatic goto(input int n);
    int g = 0;
    while (cyc < n && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) begin
      $display("FAIL goto: edge %0d never reached, at %0d", n, cyc);
      bad++;
    end
  endtask

  // write lands on edge n+1
  task automatic wr_at(input int n, input logic [1:0] a, input logic [3:0] d);
    goto(n);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    goto(n + 1);
    bus.wr_en = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.dig_mask = 4'b1111; bus.lz_blank = 1'b0;

    expect_at(0,  4'b0000, 4'h0, 0, 0, "reset");
    // free scan, all zero registers
    expect_at(1,  4'b0000, 4'h0, 0, 0, "first_guard");
    expect_at(2,  4'b0001, 4'h0, 1, 0, "dig0_first");
    expect_at(4,  4'b0001, 4'h0, 1, 0, "dig0_last");
    expect_at(5,  4'b0000, 4'h0, 0, 0, "guard1");
    expect_at(6,  4'b0010, 4'h0, 1, 0, "dig1");
    expect_at(10, 4'b0100, 4'h0, 1, 0, "dig2");
    expect_at(14, 4'b1000, 4'h0, 1, 0, "dig3");
    expect_at(16, 4'b1000, 4'h0, 1, 1, "frame1");
    expect_at(17, 4'b0000, 4'h0, 0, 0, "frame_clear");
    // reg0 written on edge 18 while digit 0 shows
    expect_at(18, 4'b0001, 4'h0, 1, 0, "pre_write");
    expect_at(19, 4'b0001, 4'h1, 1, 0, "post_write");
    // frame with 1,2,3,4
    expect_at(34, 4'b0001, 4'h1, 1, 0, "val_d0");
    expect_at(38, 4'b0010, 4'h2, 1, 0, "val_d1");
    expect_at(42, 4'b0100, 4'h3, 1, 0, "val_d2");
    expect_at(46, 4'b1000, 4'h4, 1, 0, "val_d3");
    expect_at(48, 4'b1000, 4'h4, 1, 1, "val_frame");
    expect_at(49, 4'b0000, 4'h0, 0, 0, "val_guard");
    // live write into shown digit, write coincident with tick
    expect_at(54, 4'b0010, 4'h2, 1, 0, "live_old");
    expect_at(55, 4'b0010, 4'hF, 1, 0, "live_new");
    expect_at(60, 4'b0100, 4'h3, 1, 0, "tickwr_prev");
    expect_at(62, 4'b1000, 4'h9, 1, 0, "tickwr_first");
    expect_at(64, 4'b1000, 4'h9, 1, 1, "tickwr_frame");
    // regs3..0 = 0,0,5,0 with leading-zero blanking
    expect_at(82, 4'b0001, 4'h0, 1, 0, "lz_d0");
    expect_at(86, 4'b0010, 4'h5, 1, 0, "lz_d1");
    expect_at(90, 4'b0100, 4'h0, 0, 0, "lz_d2");
    expect_at(94, 4'b1000, 4'h0, 0, 0, "lz_d3");
    expect_at(96, 4'b1000, 4'h0, 0, 1, "lz_frame");
    // dig_mask = 0101
    expect_at(98,  4'b0001, 4'h0, 1, 0, "mask_d0");
    expect_at(102, 4'b0010, 4'h5, 0, 0, "mask_d1");
    expect_at(106, 4'b0100, 4'h0, 1, 0, "mask_d2");
    expect_at(110, 4'b1000, 4'h0, 0, 0, "mask_d3");
    expect_at(111, 4'b1000, 4'h0, 1, 0, "mask_midslot");
    expect_at(112, 4'b1000, 4'h0, 1, 1, "mask_frame");
    expect_at(122, 4'b0100, 4'h0, 1, 0, "pre_reset_d2");

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wr_at(17, 2'd0, 4'h1);
    wr_at(18, 2'd1, 4'h2);
    wr_at(19, 2'd2, 4'h3);
    wr_at(20, 2'd3, 4'h4);
    wr_at(53, 2'd1, 4'hF);
    wr_at(59, 2'd3, 4'h9);
    wr_at(65, 2'd0, 4'h0);
    wr_at(66, 2'd1, 4'h5);
    wr_at(67, 2'd2, 4'h0);
    wr_at(68, 2'd3, 4'h0);
    bus.lz_blank = 1'b1;
    goto(96);
    bus.dig_mask = 4'b0101; bus.lz_blank = 1'b0;
    goto(110);
    bus.dig_mask = 4'b1111;

    // reset mid-slot on digit 2, just after an edge
    goto(122);
    @(posedge clk);
    #1 rst_n = 1'b0;
    expect_at(0, 4'b0000, 4'h0, 0, 0, "reset_midslot");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_at(1,  4'b0000, 4'h0, 0, 0, "rr_guard");
    expect_at(2,  4'b0001, 4'h0, 1, 0, "rr_d0");
    expect_at(3,  4'b0001, 4'h0, 1, 0, "rr_d0b");
    expect_at(5,  4'b0000, 4'h0, 0, 0, "rr_guard1");
    expect_at(6,  4'b0010, 4'h0, 1, 0, "rr_d1_cleared");
    expect_at(16, 4'b1000, 4'h0, 1, 1, "rr_frame");
    goto(20);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
